// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI state encodings, mode constants and parameter checks
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b01,
    ST_ACTIVE = 2'b10
  } spi_state_e;

  localparam bit CPHA           = 1'b1;
  localparam bit CPOL_IDLE_LOW  = 1'b0;
  localparam bit CPOL_IDLE_HIGH = 1'b1;

  localparam int unsigned MIN_WIDTH       = 2;
  localparam int unsigned MIN_SYNC_STAGES = 2;

  function automatic bit width_ok(input int unsigned width);
    return width >= MIN_WIDTH;
  endfunction

  function automatic bit sync_stages_ok(input int unsigned stages);
    return stages >= MIN_SYNC_STAGES;
  endfunction

endpackage

// File: rtl/spi_target_synchronizer.sv
// rtl/spi_target_synchronizer.sv - multi-flop synchroniser for one asynchronous input bit
module spi_target_synchronizer
  import spi_pkg::*;
#(
  parameter int unsigned STAGES      = 2,
  parameter bit          RESET_VALUE = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  if (!sync_stages_ok(STAGES)) begin : g_stages_check
    $error("spi_target_synchronizer: STAGES must be >= 2");
  end

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RESET_VALUE}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_target.sv
// rtl/spi_target.sv - CPHA=1 SPI target with oversampled inputs and a one-entry TX holding buffer
module spi_target
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter bit          IDLE_HIGH   = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sclk_i,
  input  logic             cs_ni,
  input  logic             mosi_i,
  output logic             miso_o,
  output logic             miso_oe_o,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             rx_valid_o,
  output logic             tx_underrun_o
);

  localparam int unsigned     CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("spi_target: WIDTH must be >= 2");
  end

  logic sclk_s, cs_s, mosi_s;
  logic sclk_q, cs_q;
  logic lead, trail, cs_fall;

  spi_target_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(IDLE_HIGH)) u_sync_sclk (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(sclk_i), .q_o(sclk_s)
  );
  spi_target_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_cs (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(cs_ni), .q_o(cs_s)
  );
  spi_target_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_mosi (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(mosi_i), .q_o(mosi_s)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sclk_q <= IDLE_HIGH;
      cs_q   <= 1'b1;
    end else begin
      sclk_q <= sclk_s;
      cs_q   <= cs_s;
    end
  end

  // Leading edge leaves the idle level, trailing edge returns to it.
  assign lead    = (sclk_q == IDLE_HIGH) && (sclk_s != IDLE_HIGH);
  assign trail   = (sclk_q != IDLE_HIGH) && (sclk_s == IDLE_HIGH);
  assign cs_fall = cs_q && !cs_s;

  spi_state_e       state;
  logic [CW-1:0]    bitcnt;
  logic [WIDTH-1:0] tx_shift, rx_shift, hold_data;
  logic             hold_full, hold_full_d, hold_write, consume;

  // A write can only land while empty, so a same-cycle consume still sees empty.
  always_comb begin
    consume     = (state == ST_ACTIVE) && !cs_s && lead && (bitcnt == '0);
    hold_write  = tx_valid_i && tx_ready_o;
    hold_full_d = hold_full;
    if (consume)    hold_full_d = 1'b0;
    if (hold_write) hold_full_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state         <= ST_IDLE;
      bitcnt        <= '0;
      tx_shift      <= '0;
      rx_shift      <= '0;
      hold_data     <= '0;
      hold_full     <= 1'b0;
      tx_ready_o    <= 1'b1;
      rx_data_o     <= '0;
      rx_valid_o    <= 1'b0;
      tx_underrun_o <= 1'b0;
      miso_o        <= 1'b0;
      miso_oe_o     <= 1'b0;
    end else begin
      hold_full     <= hold_full_d;
      tx_ready_o    <= !hold_full_d;
      rx_valid_o    <= 1'b0;
      tx_underrun_o <= 1'b0;
      if (hold_write) hold_data <= tx_data_i;

      unique case (state)
        ST_IDLE: begin
          miso_oe_o <= 1'b0;
          miso_o    <= 1'b0;
          if (cs_fall) begin
            state     <= ST_ACTIVE;
            bitcnt    <= '0;
            tx_shift  <= '0;
            miso_oe_o <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (cs_s) begin
            state     <= ST_IDLE;
            miso_oe_o <= 1'b0;
            miso_o    <= 1'b0;
          end else if (lead) begin
            if (bitcnt == '0) begin
              tx_shift      <= hold_full ? hold_data : '0;
              miso_o        <= hold_full && hold_data[WIDTH-1];
              tx_underrun_o <= !hold_full;
            end else begin
              tx_shift <= tx_shift << 1;
              miso_o   <= tx_shift[WIDTH-2];
            end
          end else if (trail) begin
            rx_shift <= {rx_shift[WIDTH-2:0], mosi_s};
            if (bitcnt == LAST_BIT) begin
              rx_data_o  <= {rx_shift[WIDTH-2:0], mosi_s};
              rx_valid_o <= 1'b1;
              bitcnt     <= '0;
            end else begin
              bitcnt <= bitcnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// tb/tb_spi_target.sv - scoreboard bench for spi_target in CPOL1/8-bit and CPOL0/16-bit builds
module tb_spi_target;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  sclk, cs_n, mosi;
  logic        miso_a, oe_a, rdy_a, rxv_a, urun_a, txv_a;
  logic [7:0]  txd_a, rxd_a;
  logic        miso_b, oe_b, rdy_b, rxv_b, urun_b, txv_b;
  logic [15:0] txd_b, rxd_b;

  int checks = 0;
  int errors = 0;
  int urun_a_cnt = 0;
  int urun_b_cnt = 0;
  logic [15:0] rx_q0[$];
  logic [15:0] rx_q1[$];
  logic [15:0] exp_a, exp_b;

  spi_target #(.WIDTH(8), .IDLE_HIGH(1'b1), .SYNC_STAGES(2)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .sclk_i(sclk[0]), .cs_ni(cs_n[0]), .mosi_i(mosi[0]),
    .miso_o(miso_a), .miso_oe_o(oe_a), .tx_data_i(txd_a), .tx_valid_i(txv_a),
    .tx_ready_o(rdy_a), .rx_data_o(rxd_a), .rx_valid_o(rxv_a), .tx_underrun_o(urun_a)
  );

  spi_target #(.WIDTH(16), .IDLE_HIGH(1'b0), .SYNC_STAGES(2)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .sclk_i(sclk[1]), .cs_ni(cs_n[1]), .mosi_i(mosi[1]),
    .miso_o(miso_b), .miso_oe_o(oe_b), .tx_data_i(txd_b), .tx_valid_i(txv_b),
    .tx_ready_o(rdy_b), .rx_data_o(rxd_b), .rx_valid_o(rxv_b), .tx_underrun_o(urun_b)
  );

  always @(negedge clk) begin
    if (urun_a) urun_a_cnt++;
    if (urun_b) urun_b_cnt++;
    if (rxv_a) begin
      checks++;
      if (rx_q0.size() == 0) begin
        errors++;
        $display("FAIL rx_a_unexpected: rx_valid with data %h, required no pulse", rxd_a);
      end else begin
        exp_a = rx_q0.pop_front();
        if (rxd_a !== exp_a[7:0]) begin
          errors++;
          $display("FAIL rx_a_data: got %h, required %h", rxd_a, exp_a[7:0]);
        end
      end
    end
    if (rxv_b) begin
      checks++;
      if (rx_q1.size() == 0) begin
        errors++;
        $display("FAIL rx_b_unexpected: rx_valid with data %h, required no pulse", rxd_b);
      end else begin
        exp_b = rx_q1.pop_front();
        if (rxd_b !== exp_b) begin
          errors++;
          $display("FAIL rx_b_data: got %h, required %h", rxd_b, exp_b);
        end
      end
    end
  end

  task automatic load(input int sel, input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    while (!(sel != 0 ? rdy_b : rdy_a) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL load_timeout dut%0d: tx_ready stayed 0, required 1", sel);
    end else begin
      if (sel != 0) begin txd_b = d; txv_b = 1'b1; end
      else begin txd_a = d[7:0]; txv_a = 1'b1; end
      @(negedge clk);
      txv_a = 1'b0;
      txv_b = 1'b0;
    end
  endtask

  // Initiator model: half-period of 4 clk cycles, mosi changes on the leading edge.
  task automatic xfer(input int sel, input logic [15:0] mo, input logic [15:0] tx_exp,
                      input int nbits, input bit end_cs);
    int   w    = (sel != 0) ? 16 : 8;
    logic idle = (sel == 0);
    logic got;
    if (nbits == w) begin
      if (sel != 0) rx_q1.push_back(mo);
      else rx_q0.push_back(mo);
    end
    cs_n[sel] = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sclk[sel] = ~idle;
      mosi[sel] = mo[w-1-i];
      repeat (4) @(negedge clk);
      got = (sel != 0) ? miso_b : miso_a;
      checks++;
      if (got !== tx_exp[w-1-i]) begin
        errors++;
        $display("FAIL miso_bit%0d dut%0d: got %b, required %b", i, sel, got, tx_exp[w-1-i]);
      end
      sclk[sel] = idle;
      repeat (4) @(negedge clk);
    end
    if (end_cs) begin
      cs_n[sel] = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({miso_a, oe_a, rdy_a, rxv_a, urun_a, rxd_a} !== {5'b00100, 8'h00}) begin
      errors++;
      $display("FAIL %s_a: got %b, required %b", tag,
               {miso_a, oe_a, rdy_a, rxv_a, urun_a, rxd_a}, {5'b00100, 8'h00});
    end
    checks++;
    if ({miso_b, oe_b, rdy_b, rxv_b, urun_b, rxd_b} !== {5'b00100, 16'h0000}) begin
      errors++;
      $display("FAIL %s_b: got %b, required %b", tag,
               {miso_b, oe_b, rdy_b, rxv_b, urun_b, rxd_b}, {5'b00100, 16'h0000});
    end
  endtask

  task automatic check_queues(input string tag);
    checks++;
    if (rx_q0.size() + rx_q1.size() != 0) begin
      errors++;
      $display("FAIL %s_rx_missing: %0d words outstanding, required 0", tag,
               rx_q0.size() + rx_q1.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      sclk = ~sclk;
      mosi = ~mosi;
      repeat (4) @(negedge clk);
    end
    sclk = 2'b01;
    mosi = 2'b00;
    repeat (4) @(negedge clk);
    check_reset_outputs("idle");
    checks++;
    if (urun_a_cnt + urun_b_cnt != 0) begin
      errors++;
      $display("FAIL idle_underrun: got %0d pulses, required 0", urun_a_cnt + urun_b_cnt);
    end
  endtask

  task automatic test_basic();
    load(0, 16'h00A5);
    checks++;
    if (rdy_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_ready_full: got %b, required 0", rdy_a);
    end
    xfer(0, 16'h003C, 16'h00A5, 8, 1'b1);
    checks++;
    if (rdy_a !== 1'b1 || urun_a_cnt != 0) begin
      errors++;
      $display("FAIL basic_ready_urun: got ready %b underruns %0d, required 1 and 0", rdy_a, urun_a_cnt);
    end
    check_queues("basic");
  endtask

  task automatic test_back_to_back();
    int u0 = urun_a_cnt;
    load(0, 16'h0081);
    fork
      begin
        xfer(0, 16'h0001, 16'h0081, 8, 1'b0);
        xfer(0, 16'h00FF, 16'h007E, 8, 1'b1);
      end
      load(0, 16'h007E);
    join
    checks++;
    if (urun_a_cnt != u0) begin
      errors++;
      $display("FAIL b2b_underrun: got %0d pulses, required 0", urun_a_cnt - u0);
    end
    check_queues("b2b");
  endtask

  task automatic test_underrun();
    int u0 = urun_a_cnt;
    xfer(0, 16'h005A, 16'h0000, 8, 1'b1);
    checks++;
    if (urun_a_cnt != u0 + 1) begin
      errors++;
      $display("FAIL underrun_count: got %0d pulses, required 1", urun_a_cnt - u0);
    end
    check_queues("underrun");
  endtask

  task automatic test_cs_abort();
    int u0 = urun_a_cnt;
    xfer(0, 16'h00F0, 16'h0000, 5, 1'b1);
    load(0, 16'h00C3);
    xfer(0, 16'h0096, 16'h00C3, 8, 1'b1);
    checks++;
    if (rxd_a !== 8'h96 || urun_a_cnt != u0 + 1) begin
      errors++;
      $display("FAIL abort_rx: got data %h underruns %0d, required 96 and 1", rxd_a, urun_a_cnt - u0);
    end
    check_queues("abort");
  endtask

  task automatic test_reset_midword();
    load(0, 16'h00AA);
    xfer(0, 16'h0000, 16'h00AA, 3, 1'b0);
    load(0, 16'h0055);
    checks++;
    if (rdy_a !== 1'b0) begin
      errors++;
      $display("FAIL midreset_full: got ready %b, required 0", rdy_a);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    cs_n = 2'b11;
    sclk = 2'b01;
    mosi = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("midreset");
    load(0, 16'h0033);
    xfer(0, 16'h0066, 16'h0033, 8, 1'b1);
    check_queues("midreset");
  endtask

  task automatic test_wide();
    load(1, 16'hBEEF);
    xfer(1, 16'hBEEF, 16'hBEEF, 16, 1'b1);
    checks++;
    if (urun_b_cnt != 0 || rdy_b !== 1'b1) begin
      errors++;
      $display("FAIL wide_status: got underruns %0d ready %b, required 0 and 1", urun_b_cnt, rdy_b);
    end
    check_queues("wide");
  endtask

  initial begin
    rst_n = 1'b0;
    sclk  = 2'b01;
    cs_n  = 2'b11;
    mosi  = 2'b00;
    txv_a = 1'b0;
    txv_b = 1'b0;
    txd_a = '0;
    txd_b = '0;
    test_reset();
    test_idle();
    test_basic();
    test_back_to_back();
    test_underrun();
    test_cs_abort();
    test_reset_midword();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
